// File: rtl/data_mem_hs_pkg.sv
// Shared types and op decoding for the handshaked RV32I data memory.
// The funct3 values are those the core LSU presents for loads and stores.
package data_mem_hs_pkg;

  typedef enum logic [3:0] {
    LB, LH, LW, LBU, LHU, SB, SH, SW, MEM_ILLEGAL
  } mem_op_e;

  typedef enum logic [1:0] {
    ERR_OK         = 2'b00,
    ERR_MISALIGNED = 2'b01,
    ERR_OOR        = 2'b10,
    ERR_ILLEGAL    = 2'b11
  } mem_err_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic mem_op_e decode_op(input logic we, input logic [2:0] funct3);
    mem_op_e op;
    op = MEM_ILLEGAL;
    if (we) begin
      case (funct3)
        F3_B:    op = SB;
        F3_H:    op = SH;
        F3_W:    op = SW;
        default: op = MEM_ILLEGAL;
      endcase
    end else begin
      case (funct3)
        F3_B:    op = LB;
        F3_H:    op = LH;
        F3_W:    op = LW;
        F3_BU:   op = LBU;
        F3_HU:   op = LHU;
        default: op = MEM_ILLEGAL;
      endcase
    end
    return op;
  endfunction

endpackage

// File: rtl/data_mem_hs_if.sv
// Request/response bus between the core LSU (master) and the data memory (slave).
interface data_mem_hs_if;

  // Each channel transfers on a rising clock edge where valid and ready are both
  // high; ready may depend on state but never on valid, and the slave holds its
  // response payload stable while rsp_valid is high and rsp_ready is low.
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/data_mem_hs_lane_align.sv
// Combinational byte-lane steering: store byte enables and lane-placed write
// data, plus extraction and sign/zero extension of load data.
module data_mem_hs_lane_align
  import data_mem_hs_pkg::*;
(
  input  mem_op_e     i_op,
  input  logic [1:0]  i_lane,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rword,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_lane, 3'b000} +: 8];
  assign w_half = i_lane[1] ? i_rword[31:16] : i_rword[15:0];

  // Write data is replicated across lanes; the byte enables pick the live ones.
  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'h0;
    o_rdata = 32'h0;
    case (i_op)
      SB: begin
        o_be    = 4'b0001 << i_lane;
        o_wdata = {4{i_wdata[7:0]}};
      end
      SH: begin
        o_be    = i_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_wdata[15:0]}};
      end
      SW: begin
        o_be    = 4'b1111;
        o_wdata = i_wdata;
      end
      LB:      o_rdata = {{24{w_byte[7]}}, w_byte};
      LBU:     o_rdata = {24'h0, w_byte};
      LH:      o_rdata = {{16{w_half[15]}}, w_half};
      LHU:     o_rdata = {16'h0, w_half};
      LW:      o_rdata = i_rword;
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_hs.sv
// Handshaked RV32I data memory: one load/store per request, WAIT_STATES access
// cycles, then a held response carrying load data and an error code.
module data_mem_hs
  import data_mem_hs_pkg::*;
#(
  parameter int unsigned DEPTH       = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  data_mem_hs_if.slave  io_bus,
  output state_e        o_dbg_state
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [32:0] SPAN    = 33'(DEPTH) << 2;
  localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  state_e      r_state;
  state_e      w_next_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr;
  logic [2:0]  r_funct3;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic [1:0]  r_err;
  logic [31:0] r_mem [DEPTH];

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_in_idle;
  logic        w_accept;
  logic        w_commit;
  logic        w_cur_we;
  logic [31:0] w_cur_addr;
  logic [2:0]  w_cur_funct3;
  logic [31:0] w_cur_wdata;
  mem_op_e     w_op;
  logic [31:0] w_off;
  logic        w_in_range;
  logic        w_misaligned;
  mem_err_e    w_err;
  logic [AW-1:0] w_idx;
  logic [31:0] w_rword;
  logic [3:0]  w_be;
  logic [31:0] w_wdata_sh;
  logic [31:0] w_load_data;

  assign w_in_idle = (r_state == S_IDLE);
  assign w_accept  = w_in_idle && io_bus.req_valid;

  always_comb begin
    w_next_state = r_state;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_req_ready = 1'b1;
        if (io_bus.req_valid) w_next_state = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) w_next_state = S_RESP;
      end
      S_RESP: begin
        w_rsp_valid = 1'b1;
        if (io_bus.rsp_ready) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // The access commits on the edge entering S_RESP; with no wait states that
  // is the accept edge itself, so the live request is used instead of the latch.
  assign w_commit     = (w_next_state == S_RESP) && (r_state != S_RESP);
  assign w_cur_we     = w_in_idle ? io_bus.req_we     : r_we;
  assign w_cur_addr   = w_in_idle ? io_bus.req_addr   : r_addr;
  assign w_cur_funct3 = w_in_idle ? io_bus.req_funct3 : r_funct3;
  assign w_cur_wdata  = w_in_idle ? io_bus.req_wdata  : r_wdata;

  assign w_op       = decode_op(w_cur_we, w_cur_funct3);
  assign w_off      = w_cur_addr - BASE_ADDR;
  assign w_in_range = (w_cur_addr >= BASE_ADDR) && ({1'b0, w_off} < SPAN);
  assign w_idx      = w_off[AW+1:2];
  assign w_rword    = r_mem[w_idx];

  always_comb begin
    w_misaligned = 1'b0;
    case (w_op)
      LH, LHU, SH: w_misaligned = w_cur_addr[0];
      LW, SW:      w_misaligned = |w_cur_addr[1:0];
      default:     w_misaligned = 1'b0;
    endcase
  end

  always_comb begin
    w_err = ERR_OK;
    if (w_op == MEM_ILLEGAL) w_err = ERR_ILLEGAL;
    else if (w_misaligned)   w_err = ERR_MISALIGNED;
    else if (!w_in_range)    w_err = ERR_OOR;
  end

  data_mem_hs_lane_align u_lane_align (
    .i_op    (w_op),
    .i_lane  (w_cur_addr[1:0]),
    .i_wdata (w_cur_wdata),
    .i_rword (w_rword),
    .o_be    (w_be),
    .o_wdata (w_wdata_sh),
    .o_rdata (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 32'h0;
      r_err   <= 2'b00;
    end else begin
      r_state <= w_next_state;
      if (w_accept) r_cnt <= WS_INIT;
      else if (r_state == S_WAIT && r_cnt != 4'd0) r_cnt <= 4'(r_cnt - 4'd1);
      if (w_commit) begin
        r_err   <= w_err;
        r_rdata <= (w_err == ERR_OK) ? w_load_data : 32'h0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_we     <= io_bus.req_we;
      r_addr   <= io_bus.req_addr;
      r_funct3 <= io_bus.req_funct3;
      r_wdata  <= io_bus.req_wdata;
    end
  end

  // RAM contents survive reset; reset on the commit edge still blocks the write.
  always_ff @(posedge clk) begin
    if (reset_n && w_commit && w_err == ERR_OK) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_sh[8*b +: 8];
      end
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_rdata = r_rdata;
  assign io_bus.rsp_err   = r_err;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_data_mem_hs.sv
// Bench for data_mem_hs: runs the same directed suite on a zero-wait and a
// three-wait instance, checking against a byte-level memory model.
module tb_data_mem_hs;
  import data_mem_hs_pkg::*;

  localparam int DEPTH = 64;
  localparam int SPAN  = DEPTH * 4;
  localparam logic [31:0] BASE = 32'h0;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  int   cyc;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUTs ----------------
  logic        sel;
  logic        t_valid, t_we, t_rrdy;
  logic [31:0] t_addr, t_wd;
  logic [2:0]  t_f3;
  state_e      dbg0, dbg3;

  data_mem_hs_if if0 ();
  data_mem_hs_if if3 ();

  assign if0.req_valid  = t_valid & ~sel;
  assign if3.req_valid  = t_valid & sel;
  assign if0.req_we     = t_we;
  assign if3.req_we     = t_we;
  assign if0.req_addr   = t_addr;
  assign if3.req_addr   = t_addr;
  assign if0.req_funct3 = t_f3;
  assign if3.req_funct3 = t_f3;
  assign if0.req_wdata  = t_wd;
  assign if3.req_wdata  = t_wd;
  assign if0.rsp_ready  = t_rrdy;
  assign if3.rsp_ready  = t_rrdy;

  data_mem_hs #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .io_bus(if0.slave), .o_dbg_state(dbg0));
  data_mem_hs #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .reset_n(rst_n), .io_bus(if3.slave), .o_dbg_state(dbg3));

  logic        w_req_ready, w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic [1:0]  w_rsp_err;
  state_e      w_dbg;
  assign w_req_ready = sel ? if3.req_ready : if0.req_ready;
  assign w_rsp_valid = sel ? if3.rsp_valid : if0.rsp_valid;
  assign w_rsp_rdata = sel ? if3.rsp_rdata : if0.rsp_rdata;
  assign w_rsp_err   = sel ? if3.rsp_err   : if0.rsp_err;
  assign w_dbg       = sel ? dbg3 : dbg0;

  // ---------------- scoreboard / model ----------------
  int          checks, failures;
  int          cur_ws;
  int          acc_cyc;
  logic [33:0] exp_q[$];
  logic [7:0]  mb [2][SPAN];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s ws=%0d actual=%h required=%h", nm, cur_ws, act, exp);
    end
  endfunction

  function automatic void model(input int s, input logic we, input logic [31:0] a,
                                input logic [2:0] f3, input logic [31:0] wd,
                                output logic [31:0] rd, output logic [1:0] er);
    int     sz;
    bit     uns, legal;
    longint off, v;
    sz = 4; uns = 0; legal = 1; rd = 32'h0;
    if (we) begin
      case (f3)
        3'd0: sz = 1;
        3'd1: sz = 2;
        3'd2: sz = 4;
        default: legal = 0;
      endcase
    end else begin
      case (f3)
        3'd0: sz = 1;
        3'd1: sz = 2;
        3'd2: sz = 4;
        3'd4: begin sz = 1; uns = 1; end
        3'd5: begin sz = 2; uns = 1; end
        default: legal = 0;
      endcase
    end
    off = longint'(a) - longint'(BASE);
    if (!legal) er = 2'b11;
    else if ((longint'(a) % sz) != 0) er = 2'b01;
    else if (off < 0 || off >= SPAN) er = 2'b10;
    else er = 2'b00;
    if (er == 2'b00) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mb[s][int'(off) + i] = wd[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < sz; i++) v = v | (longint'(mb[s][int'(off) + i]) << (8*i));
        if (!uns && sz < 4 && v[8*sz-1]) v = v - (longint'(1) << (8*sz));
        rd = v[31:0];
      end
    end
  endfunction

  // Response checker: outputs are meaningful on every cycle rsp_valid is high.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (rst_n && w_rsp_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp ws=%0d actual=valid required=idle", cur_ws);
        end else begin
          chk("rsp_rdata", w_rsp_rdata, exp_q[0][31:0]);
          chk("rsp_err", {30'b0, w_rsp_err}, {30'b0, exp_q[0][33:32]});
          if (t_rrdy) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic we, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd);
    logic [31:0] erd;
    logic [1:0]  eer;
    int          n;
    model(int'(sel), we, a, f3, wd, erd, eer);
    exp_q.push_back({eer, erd});
    @(negedge clk);
    t_valid = 1'b1; t_we = we; t_addr = a; t_f3 = f3; t_wd = wd;
    n = 0;
    while (!w_req_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!w_req_ready) chk("accept_timeout", 32'd0, 32'd1);
    acc_cyc = cyc;
    @(negedge clk);
    t_valid = 1'b0;
    t_we = 1'($urandom_range(0, 1)); t_addr = $urandom; t_f3 = 3'($urandom_range(0, 7));
    t_wd = $urandom;
  endtask

  task automatic wait_rsp(output logic [31:0] rd, output logic [1:0] er, output int lat);
    lat = 1;
    while (!w_rsp_valid && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    if (!w_rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    rd = w_rsp_rdata;
    er = w_rsp_err;
  endtask

  task automatic xfer(input string nm, input logic we, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic [1:0] exp_er);
    logic [31:0] rd;
    logic [1:0]  er;
    int          lat;
    issue(we, a, f3, wd);
    wait_rsp(rd, er, lat);
    chk({nm, "_rdata"}, rd, exp_rd);
    chk({nm, "_err"}, {30'b0, er}, {30'b0, exp_er});
    chk({nm, "_latency"}, lat, 32'(1 + cur_ws));
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst_n = 1'b0;
    t_valid = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk({nm, "_rsp_valid"}, {31'b0, w_rsp_valid}, 32'd0);
    chk({nm, "_req_ready"}, {31'b0, w_req_ready}, 32'd1);
    chk({nm, "_rsp_rdata"}, w_rsp_rdata, 32'd0);
    chk({nm, "_rsp_err"}, {30'b0, w_rsp_err}, 32'd0);
    chk({nm, "_state"}, {30'b0, w_dbg}, {30'b0, S_IDLE});
    rst_n = 1'b1;
    t_rrdy = 1'b1;
  endtask

  // Unmodelled store, reset asserted k cycles after the request cycle.
  task automatic abort_store(input int k, input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    t_valid = 1'b1; t_we = 1'b1; t_addr = a; t_f3 = F3_W; t_wd = wd;
    if (k == 0) rst_n = 1'b0;
    @(negedge clk);
    t_valid = 1'b0;
    for (int i = 1; i <= k; i++) begin
      if (i == k) rst_n = 1'b0;
      @(negedge clk);
    end
    chk("abort_rsp_valid", {31'b0, w_rsp_valid}, 32'd0);
    chk("abort_req_ready", {31'b0, w_req_ready}, 32'd1);
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic run_suite();
    logic [31:0] rd0, rd;
    logic [1:0]  er0, er;
    int          lat, prev;
    do_reset("reset");
    xfer("sw_base", 1, 32'h0,  F3_W, 32'hCAFEF00D, 32'h0, 2'b00);
    xfer("sw_10",   1, 32'h10, F3_W, 32'hDEADBEEF, 32'h0, 2'b00);
    xfer("lw_10",   0, 32'h10, F3_W, 32'h0, 32'hDEADBEEF, 2'b00);
    xfer("sb_13",   1, 32'h13, F3_B, 32'h00000080, 32'h0, 2'b00);
    xfer("lw_sb",   0, 32'h10, F3_W, 32'h0, 32'h80ADBEEF, 2'b00);
    xfer("lb_13",   0, 32'h13, F3_B, 32'h0, 32'hFFFFFF80, 2'b00);
    xfer("lbu_13",  0, 32'h13, F3_BU, 32'h0, 32'h00000080, 2'b00);
    xfer("sh_12",   1, 32'h12, F3_H, 32'h00007FFF, 32'h0, 2'b00);
    xfer("lh_12",   0, 32'h12, F3_H, 32'h0, 32'h00007FFF, 2'b00);
    xfer("lh_11",   0, 32'h11, F3_H, 32'h0, 32'h0, 2'b01);
    xfer("sw_11",   1, 32'h11, F3_W, 32'h55555555, 32'h0, 2'b01);
    xfer("lw_keep", 0, 32'h10, F3_W, 32'h0, 32'h7FFFBEEF, 2'b00);
    xfer("lhu_10",  0, 32'h10, F3_HU, 32'h0, 32'h0000BEEF, 2'b00);
    xfer("lh_10",   0, 32'h10, F3_H, 32'h0, 32'hFFFFBEEF, 2'b00);
    xfer("lb_10",   0, 32'h10, F3_B, 32'h0, 32'hFFFFFFEF, 2'b00);
    xfer("lbu_11",  0, 32'h11, F3_BU, 32'h0, 32'h000000BE, 2'b00);

    prev = 0;
    for (int i = 0; i < 4; i++) begin
      xfer("b2b", 0, 32'h10, F3_W, 32'h0, 32'h7FFFBEEF, 2'b00);
      if (i > 0) chk("b2b_spacing", acc_cyc - prev, 32'(2 + cur_ws));
      prev = acc_cyc;
    end

    @(negedge clk);
    t_rrdy = 1'b0;
    issue(0, 32'h10, F3_W, 32'h0);
    wait_rsp(rd0, er0, lat);
    chk("stall_rdata", rd0, 32'h7FFFBEEF);
    for (int i = 0; i < 5; i++) begin
      chk("stall_req_ready", {31'b0, w_req_ready}, 32'd0);
      chk("stall_rsp_valid", {31'b0, w_rsp_valid}, 32'd1);
      chk("stall_hold_rdata", w_rsp_rdata, rd0);
      chk("stall_hold_err", {30'b0, w_rsp_err}, {30'b0, er0});
      t_valid = (i == 1);
      t_we = 1'b1; t_addr = 32'h10; t_f3 = F3_W; t_wd = 32'h0;
      @(negedge clk);
    end
    t_valid = 1'b0;
    t_rrdy = 1'b1;
    xfer("lw_after_stall", 0, 32'h10, F3_W, 32'h0, 32'h7FFFBEEF, 2'b00);

    xfer("sw_oor",     1, 32'h100, F3_W, 32'h12345678, 32'h0, 2'b10);
    xfer("lw_base",    0, 32'h0, F3_W, 32'h0, 32'hCAFEF00D, 2'b00);
    xfer("lw_top",     0, 32'hFFFFFFFC, F3_W, 32'h0, 32'h0, 2'b10);
    xfer("lbu_oor",    0, 32'h101, F3_BU, 32'h0, 32'h0, 2'b10);
    xfer("lw_mis_oor", 0, 32'h102, F3_W, 32'h0, 32'h0, 2'b01);
    xfer("ld_f3_011",  0, 32'h10, 3'b011, 32'h0, 32'h0, 2'b11);
    xfer("ld_f3_111",  0, 32'h10, 3'b111, 32'h0, 32'h0, 2'b11);
    xfer("st_f3_100",  1, 32'h11, 3'b100, 32'h1, 32'h0, 2'b11);
    xfer("st_f3_011",  1, 32'h100, 3'b011, 32'h1, 32'h0, 2'b11);
    xfer("lw_unchg",   0, 32'h10, F3_W, 32'h0, 32'h7FFFBEEF, 2'b00);

    xfer("sw_20", 1, 32'h20, F3_W, 32'h11111111, 32'h0, 2'b00);
    if (cur_ws == 0) begin
      abort_store(0, 32'h20, 32'h12345678);
      xfer("lw_20_k0", 0, 32'h20, F3_W, 32'h0, 32'h11111111, 2'b00);
    end else begin
      abort_store(1, 32'h20, 32'h12345678);
      xfer("lw_20_k1", 0, 32'h20, F3_W, 32'h0, 32'h11111111, 2'b00);
      abort_store(cur_ws, 32'h20, 32'h12345678);
      xfer("lw_20_kc", 0, 32'h20, F3_W, 32'h0, 32'h11111111, 2'b00);
    end

    @(negedge clk);
    t_rrdy = 1'b0;
    issue(0, 32'h10, F3_W, 32'h0);
    wait_rsp(rd, er, lat);
    do_reset("drop");
    xfer("lw_after_drop", 0, 32'h10, F3_W, 32'h0, 32'h7FFFBEEF, 2'b00);
  endtask

  // ---------------- main ----------------
  initial begin
    cyc = 0; checks = 0; failures = 0; acc_cyc = 0;
    rst_n = 1'b0; sel = 1'b0; cur_ws = 0;
    t_valid = 1'b0; t_we = 1'b0; t_addr = 32'h0; t_f3 = 3'b0; t_wd = 32'h0; t_rrdy = 1'b1;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      cur_ws = (s == 0) ? 0 : 3;
      run_suite();
      repeat (3) @(negedge clk);
    end
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
